// File: rtl/pipe_hazard_if.sv
// Decode/execute hazard-control bundle between the issue stage and the
// hazard controller. The master side drives the decoding instruction and
// the branch-resolve pulse. The slave side (the controller) returns the
// handshake, the forwarding selects and the stall/flush indications.
interface pipe_hazard_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
);
    localparam int FW = $clog2(NUM_FWD + 1);

    logic              id_valid;
    logic              id_ready;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_use;
    logic              id_rt_use;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_addr;
    logic              id_is_load;
    logic              ex_br_taken;
    logic [FW-1:0]     fwd_a_sel;
    logic [FW-1:0]     fwd_b_sel;
    logic              stall;
    logic              flush;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
               id_wr_en, id_wr_addr, id_is_load, ex_br_taken,
        input  id_ready, fwd_a_sel, fwd_b_sel, stall, flush
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
               id_wr_en, id_wr_addr, id_is_load, ex_br_taken,
        output id_ready, fwd_a_sel, fwd_b_sel, stall, flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks pending register writes in a tag pipe,
// selects forwarding sources, stalls on load-use and flushes on taken
// branches for BR_FLUSH cycles.
// Optional: define HAZ_STATS_EN to add saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NUM_FWD    = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_FLUSH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_hazard_if.slave hz
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0] stat_stall,
    output logic [15:0] stat_flush
`endif
);
    localparam int FW = $clog2(NUM_FWD + 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [NUM_FWD:1]  tag_vld_q;
    logic [NUM_FWD:1]  tag_ld_q;
    logic [REG_AW-1:0] tag_addr_q [1:NUM_FWD];

    logic [FW-1:0]     fwd_a_q, fwd_b_q;
    logic [FW-1:0]     sel_a_s, sel_b_s;
    logic              ld_a_s, ld_b_s;
    logic              hazard_s, flush_s, stall_s, issue_s;

    // Nearest-producer search: scan from the oldest stage to the youngest so
    // that the lowest-numbered matching stage is the one that sticks.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        ld_a_s  = 1'b0;
        ld_b_s  = 1'b0;
        for (int k = NUM_FWD; k >= 1; k--) begin
            if (hz.id_rs_use && (hz.id_rs != '0) && tag_vld_q[k] &&
                (tag_addr_q[k] == hz.id_rs)) begin
                sel_a_s = FW'(k);
                ld_a_s  = tag_ld_q[k] && (k < LOAD_STAGE);
            end else begin
                sel_a_s = sel_a_s;
                ld_a_s  = ld_a_s;
            end
            if (hz.id_rt_use && (hz.id_rt != '0) && tag_vld_q[k] &&
                (tag_addr_q[k] == hz.id_rt)) begin
                sel_b_s = FW'(k);
                ld_b_s  = tag_ld_q[k] && (k < LOAD_STAGE);
            end else begin
                sel_b_s = sel_b_s;
                ld_b_s  = ld_b_s;
            end
        end
    end

    // A taken branch this cycle outranks a load-use stall: the decoding
    // instruction is on the wrong path and is discarded anyway.
    assign flush_s  = (state_q == ST_FLUSH);
    assign hazard_s = hz.id_valid & (ld_a_s | ld_b_s);
    assign stall_s  = hazard_s & ~flush_s & ~hz.ex_br_taken;
    assign issue_s  = hz.id_valid & ~stall_s & ~flush_s;

    assign hz.stall     = stall_s;
    assign hz.flush     = flush_s;
    assign hz.id_ready  = ~stall_s & ~flush_s;
    assign hz.fwd_a_sel = fwd_a_q;
    assign hz.fwd_b_sel = fwd_b_q;

    // Flush FSM next state: a branch (re)arms the counter, otherwise FLUSH
    // counts down to zero and then returns to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hz.ex_br_taken) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 4'(BR_FLUSH - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (hz.ex_br_taken) begin
                    cnt_d = 4'(BR_FLUSH - 1);
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Flush FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tag pipe shift; the entry in the last stage falls off (now in the
    // register file). An instruction issued alongside a taken branch is
    // wrong-path, so it enters as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_ld_q  <= '0;
            for (int k = 1; k <= NUM_FWD; k++) begin
                tag_addr_q[k] <= '0;
            end
        end else begin
            for (int k = 2; k <= NUM_FWD; k++) begin
                tag_vld_q[k]  <= tag_vld_q[k-1];
                tag_ld_q[k]   <= tag_ld_q[k-1];
                tag_addr_q[k] <= tag_addr_q[k-1];
            end
            tag_vld_q[1]  <= issue_s & ~hz.ex_br_taken & hz.id_wr_en &
                             (hz.id_wr_addr != '0);
            tag_ld_q[1]   <= hz.id_is_load;
            tag_addr_q[1] <= hz.id_wr_addr;
        end
    end

    // Forwarding selects for the instruction entering EX; zero on no issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else if (issue_s) begin
            fwd_a_q <= sel_a_s;
            fwd_b_q <= sel_b_s;
        end else begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stat_stall_q, stat_flush_q;

    assign stat_stall = stat_stall_q;
    assign stat_flush = stat_flush_q;

    // Saturating event counters: stall cycles and RUN->FLUSH entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q <= 16'd0;
            stat_flush_q <= 16'd0;
        end else begin
            if (stall_s && (stat_stall_q != 16'hFFFF)) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end else begin
                stat_stall_q <= stat_stall_q;
            end
            if ((state_q == ST_RUN) && hz.ex_br_taken &&
                (stat_flush_q != 16'hFFFF)) begin
                stat_flush_q <= stat_flush_q + 16'd1;
            end else begin
                stat_flush_q <= stat_flush_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (default parameters): directed
// vector table, reset-abort sequence and randomized run against a
// history-based reference model.
module tb_pipe_hazard_ctrl;
    localparam int NUM_FWD    = 3;
    localparam int LOAD_STAGE = 2;
    localparam int BR_FLUSH   = 2;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    pipe_hazard_if #(.REG_AW(5), .NUM_FWD(NUM_FWD)) hif ();

`ifdef HAZ_STATS_EN
    logic [15:0] stat_stall, stat_flush;
`endif

    pipe_hazard_ctrl #(
        .REG_AW(5), .NUM_FWD(NUM_FWD), .LOAD_STAGE(LOAD_STAGE), .BR_FLUSH(BR_FLUSH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hz(hif.slave)
`ifdef HAZ_STATS_EN
        ,
        .stat_stall(stat_stall),
        .stat_flush(stat_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v; int rs; int rt; logic rsu; logic rtu; logic we; int wa; logic ld; logic br;
        logic e_stall; logic e_ready; logic e_flush; int e_a; int e_b; logic dc;
    } vec_t;

    typedef struct { int addr; bit ld; int cyc; } ent_t;

    vec_t tbl[25];
    ent_t hist[$];
    int   t_cyc, flush_until, m_stalls, m_flushes, exp_a, exp_b;
    bit   dc_fwd;

    function automatic vec_t mk(input logic v, input int rs, input int rt, input logic rsu,
                                input logic rtu, input logic we, input int wa, input logic ld,
                                input logic br, input logic st, input logic rdy, input logic fl,
                                input int ea, input int eb, input logic dc);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.rsu = rsu; r.rtu = rtu; r.we = we; r.wa = wa;
        r.ld = ld; r.br = br; r.e_stall = st; r.e_ready = rdy; r.e_flush = fl;
        r.e_a = ea; r.e_b = eb; r.dc = dc;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic rsu,
                         input logic rtu, input logic we, input int wa, input logic ld,
                         input logic br);
        hif.id_valid    = v;
        hif.id_rs       = 5'(rs);
        hif.id_rt       = 5'(rt);
        hif.id_rs_use   = rsu;
        hif.id_rt_use   = rtu;
        hif.id_wr_en    = we;
        hif.id_wr_addr  = 5'(wa);
        hif.id_is_load  = ld;
        hif.ex_br_taken = br;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Reset with an in-reset check, release at the falling edge, one idle cycle.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flush", int'(hif.flush), 0);
        chk("reset_stall", int'(hif.stall), 0);
        chk("reset_ready", int'(hif.id_ready), 1);
        chk("reset_fwd_a", int'(hif.fwd_a_sel), 0);
        chk("reset_fwd_b", int'(hif.fwd_b_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        hist.delete();
        t_cyc = 0; flush_until = 0; m_stalls = 0; m_flushes = 0;
        exp_a = 0; exp_b = 0; dc_fwd = 1'b0;
    endtask

    // Youngest pending writer of src (age 1 = stage 1); 0 if none.
    function automatic int find(input int src, input bit use_f, output bit ld);
        int best;
        best = 0;
        ld   = 1'b0;
        if (use_f && src != 0) begin
            foreach (hist[i]) begin
                int age;
                age = t_cyc - hist[i].cyc;
                if (hist[i].addr == src && age >= 1 && age <= NUM_FWD &&
                    (best == 0 || age < best)) begin
                    best = age;
                    ld   = hist[i].ld;
                end
            end
        end
        return best;
    endfunction

    task automatic rnd_step();
        logic v, rsu, rtu, we, ld, br;
        int   rs, rt, wa, ma, mb;
        bit   lda, ldb, fl_e, hz_e, st_e, rdy_e, iss;
        v   = ($urandom_range(3, 0) != 0);
        rs  = $urandom_range(7, 0);
        rt  = $urandom_range(7, 0);
        rsu = $urandom_range(1, 0) == 1;
        rtu = $urandom_range(1, 0) == 1;
        we  = $urandom_range(3, 0) != 0;
        wa  = $urandom_range(7, 0);
        ld  = $urandom_range(2, 0) == 0;
        br  = $urandom_range(11, 0) == 0;
        drive(v, rs, rt, rsu, rtu, we, wa, ld, br);
        @(negedge clk);
        t_cyc++;
        while (hist.size() > 0 && (t_cyc - hist[0].cyc) > NUM_FWD) void'(hist.pop_front());
        ma    = find(rs, rsu, lda);
        mb    = find(rt, rtu, ldb);
        fl_e  = (t_cyc <= flush_until);
        hz_e  = v && ((ma != 0 && lda && ma < LOAD_STAGE) || (mb != 0 && ldb && mb < LOAD_STAGE));
        st_e  = hz_e && !fl_e && !br;
        rdy_e = !st_e && !fl_e;
        iss   = v && rdy_e;
        chk($sformatf("rnd%0d_stall", t_cyc), int'(hif.stall), int'(st_e));
        chk($sformatf("rnd%0d_flush", t_cyc), int'(hif.flush), int'(fl_e));
        chk($sformatf("rnd%0d_ready", t_cyc), int'(hif.id_ready), int'(rdy_e));
        if (!dc_fwd) begin
            chk($sformatf("rnd%0d_fwd_a", t_cyc), int'(hif.fwd_a_sel), exp_a);
            chk($sformatf("rnd%0d_fwd_b", t_cyc), int'(hif.fwd_b_sel), exp_b);
        end
        exp_a  = iss ? ma : 0;
        exp_b  = iss ? mb : 0;
        dc_fwd = iss && br;
        if (iss && we && wa != 0 && !br) begin
            ent_t e;
            e.addr = wa; e.ld = ld; e.cyc = t_cyc;
            hist.push_back(e);
        end
        if (st_e) m_stalls++;
        if (br) begin
            if (!fl_e) m_flushes++;
            flush_until = t_cyc + BR_FLUSH;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b1;
        idle();
        #2;
        do_reset();

        //            v   rs rt rsu  rtu  we  wa ld   br   stall rdy fl   a  b  dc
        tbl[0]  = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // lw r5
        tbl[1]  = mk(1'b1, 5, 7, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0); // add r6,r5,r7 stalls
        tbl[2]  = mk(1'b1, 5, 7, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // issues
        tbl[3]  = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b0); // add r3; sel a=2
        tbl[4]  = mk(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // sub r4,r3,r3
        tbl[5]  = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
        tbl[6]  = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // write r3
        tbl[7]  = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tbl[8]  = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // write r3 again
        tbl[9]  = mk(1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // read r3,r0; write r0
        tbl[10] = mk(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0); // read r0
        tbl[11] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // wrong-path r8 + branch
        tbl[12] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[13] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[14] = mk(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // read r8
        tbl[15] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // r8 killed; branch
        tbl[16] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0); // branch in FLUSH
        tbl[17] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[18] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[19] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tbl[20] = mk(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // lw r5
        tbl[21] = mk(1'b1, 5, 7, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0); // hazard + branch
        tbl[22] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        tbl[23] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[24] = mk(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu,
                  tbl[i].we, tbl[i].wa, tbl[i].ld, tbl[i].br);
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), int'(hif.stall), int'(tbl[i].e_stall));
            chk($sformatf("vec%0d_ready", i), int'(hif.id_ready), int'(tbl[i].e_ready));
            chk($sformatf("vec%0d_flush", i), int'(hif.flush), int'(tbl[i].e_flush));
            if (!tbl[i].dc) begin
                chk($sformatf("vec%0d_fwd_a", i), int'(hif.fwd_a_sel), tbl[i].e_a);
                chk($sformatf("vec%0d_fwd_b", i), int'(hif.fwd_b_sel), tbl[i].e_b);
            end
            @(posedge clk);
            #1;
        end
`ifdef HAZ_STATS_EN
        chk("vec_stat_stall", int'(stat_stall), 1);
        chk("vec_stat_flush", int'(stat_flush), 3);
`endif

        // Asynchronous reset in the middle of a flush with a pending write.
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        idle();
        #1;
        chk("abort_pre_flush", int'(hif.flush), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_flush", int'(hif.flush), 0);
        chk("abort_stall", int'(hif.stall), 0);
        chk("abort_ready", int'(hif.id_ready), 1);
        chk("abort_fwd_a", int'(hif.fwd_a_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 12, 12, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("abort_read_stall", int'(hif.stall), 0);
        chk("abort_read_flush", int'(hif.flush), 0);
        chk("abort_read_ready", int'(hif.id_ready), 1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("abort_read_fwd_a", int'(hif.fwd_a_sel), 0);
        chk("abort_read_fwd_b", int'(hif.fwd_b_sel), 0);
        @(posedge clk); #1;

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 600; i++) rnd_step();
        idle();
`ifdef HAZ_STATS_EN
        @(negedge clk);
        chk("rnd_stat_stall", int'(stat_stall), m_stalls);
        chk("rnd_stat_flush", int'(stat_flush), m_flushes);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
